risc_run_monitor: RTL

Synthesisable run controller and end-of-program detector for the 16-bit RISC core and its wider successors. It sits beside the core in the top-level simulation harness and watches the core's PC and retire strobe. It counts cycles and retired instructions, detects the "jump-to-self" halt idiom, and enforces a cycle budget. The harness ends simulation on `done` instead of after a fixed simulation time.

---
 rtl/risc_run_monitor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/risc_run_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | risc_run_monitor: run controller, cycle budget and jump-to-self halt     |
// | detector for the RISC core simulation harness.          Revision: 1.0    |
// +--------------------------------------------------------------------------+
module risc_run_monitor #(
  parameter int PC_WIDTH    = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int MAX_CYCLES  = 10000,
  parameter int HALT_REPEAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [PC_WIDTH-1:0]  pc_i,
  input  logic                 pc_valid_i,
  input  logic                 retire_i,
  output logic                 running_o,
  output logic                 halted_o,
  output logic                 timeout_o,
  output logic                 done_o,
  output logic                 done_pulse_o,
  output logic [CNT_WIDTH-1:0] cycle_count_o,
  output logic [CNT_WIDTH-1:0] retire_count_o
);

  localparam int MW = $clog2(HALT_REPEAT + 1);
  localparam logic [CNT_WIDTH-1:0] c_MAX_CNT = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [MW-1:0]        c_HALT    = MW'(HALT_REPEAT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] retire_q, retire_d;
  logic [MW-1:0]        match_q, match_d;
  logic [PC_WIDTH-1:0]  last_pc_q, last_pc_d;
  logic                 have_last_q, have_last_d;
  logic                 pulse_q, pulse_d;

  logic                 w_same_pc;
  logic [MW-1:0]        w_match_inc;
  logic [CNT_WIDTH-1:0] w_cycle_inc;

  assign w_same_pc   = have_last_q && (pc_i == last_pc_q);
  assign w_match_inc = match_q + MW'(1);
  assign w_cycle_inc = cycle_q + CNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    retire_d    = retire_q;
    match_d     = match_q;
    last_pc_d   = last_pc_q;
    have_last_d = have_last_q;
    pulse_d     = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          cycle_d  = w_cycle_inc;
          retire_d = retire_q + CNT_WIDTH'(retire_i);
          if (pc_valid_i) begin
            match_d     = w_same_pc ? w_match_inc : '0;
            last_pc_d   = pc_i;
            have_last_d = 1'b1;
          end
          // Halt takes priority when both terminations land on the same edge.
          if (pc_valid_i && w_same_pc && (w_match_inc == c_HALT)) begin
            state_d = ST_HALTED;
            pulse_d = 1'b1;
          end else if (w_cycle_inc == c_MAX_CNT) begin
            state_d = ST_TIMEOUT;
            pulse_d = 1'b1;
          end
        end
        default: begin
          if (start_i) begin
            state_d     = ST_RUN;
            cycle_d     = '0;
            retire_d    = '0;
            match_d     = '0;
            have_last_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cycle_q     <= '0;
      retire_q    <= '0;
      match_q     <= '0;
      last_pc_q   <= '0;
      have_last_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      retire_q    <= retire_d;
      match_q     <= match_d;
      last_pc_q   <= last_pc_d;
      have_last_q <= have_last_d;
      pulse_q     <= pulse_d;
    end
  end

  assign running_o      = (state_q == ST_RUN);
  assign halted_o       = (state_q == ST_HALTED);
  assign timeout_o      = (state_q == ST_TIMEOUT);
  assign done_o         = halted_o | timeout_o;
  assign done_pulse_o   = pulse_q;
  assign cycle_count_o  = cycle_q;
  assign retire_count_o = retire_q;

endmodule
`default_nettype wire
